join_collector: RTL and testbench
=================================

Name: join_collector

Overview:
- Receiving end of a fork/join pair: two independent result channels (A, B) launched in parallel complete at different times.
- The block holds whichever result arrives first, waits for its partner, then presents both together as one joined output beat.
- A partner that never arrives is dropped after a timeout and flagged.
- Sits between parallel compute lanes and the single downstream consumer.

Parameters:
- WIDTH, 1, data width of each result channel.
- TIMEOUT, 16, cycles to wait for a missing partner; 0 disables the timeout.
- CNT_W, 8, width of the join counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  channel A result valid.
- a_data  input  WIDTH  channel A result.
- a_ready  output  1  channel A slot empty, can accept.
- b_valid  input  1  channel B result valid.
- b_data  input  WIDTH  channel B result.
- b_ready  output  1  channel B slot empty, can accept.
- out_valid  output  1  joined pair available.
- out1  output  WIDTH  held A result.
- out2  output  WIDTH  held B result.
- out_ready  input  1  downstream accepts joined pair.
- err  output  1  one-cycle pulse: partner timed out, held result discarded.
- join_cnt  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; out1/out2/out_valid/err/join_cnt/timer = 0. Reset mid-operation discards any held result, with no err pulse. While rst=1, a_ready=b_ready=0.
- Transfer rules: an input is accepted when valid && ready at the clock edge. The output handshake is out_valid && out_ready.
- States and signals:
  - IDLE: a_ready=1, b_ready=1.
  - HOLD_A: A held; a_ready=0, b_ready=1.
  - HOLD_B: B held; a_ready=1, b_ready=0.
  - FULL: both held; a_ready=b_ready=0, out_valid=1.
- a_ready, b_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
- Transitions:
  - IDLE: A only -> HOLD_A; B only -> HOLD_B; both in the same cycle -> FULL.
  - HOLD_A: B accepted -> FULL; else timeout -> IDLE.
  - HOLD_B: mirror of HOLD_A.
  - FULL: out_ready=1 -> IDLE; else stay, with out1/out2 stable.
- Latency: joined output appears the cycle after the second accept. Minimum join period is 2 cycles, because no input is accepted while in FULL.
- Data capture: out1 loads a_data on A accept; out2 loads b_data on B accept. Both retain their value until the next accept on the same channel (not cleared on IDLE).
- Timer:
  - Cleared on entry to HOLD_A/HOLD_B, then increments each cycle in HOLD.
  - When timer == TIMEOUT-1 and the partner is not accepted that cycle: err=1 for exactly one cycle (registered) and return to IDLE.
  - Partner arriving in the same cycle as expiry wins: go to FULL, no err.
  - TIMEOUT=0: never expires.
- join_cnt: increments by 1 per output handshake and wraps from all-ones to 0.
- Holding ready off already stalls a channel; a_valid asserted while a_ready=0 is ignored and needs no special handling.

Test Plan:
- Reset, then a_valid=1, a_data=1 at cycle 1 and b_valid=1, b_data=0 at cycle 4, out_ready=1 -> out_valid=1 at cycle 5 only, with out1=1, out2=0, join_cnt=1, err=0. a_ready=0 during cycles 2-5.
- A and B valid in the same cycle (data 1,1), out_ready=0 for 3 cycles then 1 -> out_valid held 4 cycles, out1/out2=1/1 stable, a_ready=b_ready=0 throughout, join_cnt 0->1 after the handshake.
- B only accepted, no A, TIMEOUT=16 -> err pulses exactly once 16 cycles after entering HOLD_B, state returns to IDLE, b_ready=1 next cycle, join_cnt unchanged.
- B held with A accepted on the expiry cycle (timer=15) -> FULL, no err, out_valid next cycle.
- rst asserted while in HOLD_A -> next cycle IDLE, out_valid=0, err=0, join_cnt=0. A fresh A/B pair then joins normally.
- 256 back-to-back joins with CNT_W=8 and out_ready=1 -> join_cnt wraps to 0; output asserts every 2 cycles with no lost pair.

Source files
------------

// File: rtl/join_collector_if.sv
// Handshake bundle for join_collector: two result channels in, one joined beat out.
// Handshake rule for every channel here: a beat transfers on a rising clk edge
// where valid && ready are both high; ready never depends combinationally on valid.
interface join_collector_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             out_ready;
  logic             err;
  logic [CNT_W-1:0] join_cnt;

  // Producer/consumer side: drives results and downstream ready.
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out1, out2, err, join_cnt
  );

  // Collector side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out1, out2, err, join_cnt
  );
endinterface

// File: rtl/join_collector.sv
// join_collector: holds whichever of A/B completes first, waits for the partner,
// then presents both as one joined beat. A lone result is dropped after TIMEOUT
// cycles with a one-cycle err pulse. TIMEOUT = 0 waits forever.
module join_collector #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  join_collector_if.slave   bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2,
    FULL   = 2'd3
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_rdy, b_rdy, a_acc, b_acc, out_hs, timeout_hit;

  // Ready/valid decode from registered state; rst only forces ready low.
  assign a_rdy       = !rst && (state_q == IDLE || state_q == HOLD_B);
  assign b_rdy       = !rst && (state_q == IDLE || state_q == HOLD_A);
  assign a_acc       = bus.a_valid && a_rdy;
  assign b_acc       = bus.b_valid && b_rdy;
  assign out_hs      = (state_q == FULL) && bus.out_ready;
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == T_LAST);

  // Next-state, timer, data capture and join counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (a_acc) out1_d = bus.a_data;
    if (b_acc) out2_d = bus.b_data;

    unique case (state_q)
      IDLE: begin
        if (a_acc && b_acc) begin
          state_d = FULL;
        end else if (a_acc) begin
          state_d = HOLD_A;
          timer_d = '0;
        end else if (b_acc) begin
          state_d = HOLD_B;
          timer_d = '0;
        end
      end
      HOLD_A: begin
        // A partner landing on the expiry cycle still completes the join.
        if (b_acc) begin
          state_d = FULL;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD_B: begin
        if (a_acc) begin
          state_d = FULL;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FULL: begin
        if (out_hs) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.err       = err_q;
  assign bus.join_cnt  = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_join_collector.sv
// Bench for join_collector: directed scenarios plus random traffic, checked
// against a held-slot reference model and a pair scoreboard.
module tb_join_collector;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam int W       = 2 * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  join_collector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  logic [1:0] dbg_state;

  join_collector #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge and hold for one full cycle.
  task automatic drive(input bit av, input logic [WIDTH-1:0] ad,
                       input bit bv, input logic [WIDTH-1:0] bd, input bit ordy);
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, ordy);
  endtask

  // ---------------- reference model ----------------
  // Two result slots; a pair is complete when both slots are filled. A lone
  // slot waits at most TIMEOUT cycles. Model state describes the cycle after
  // the most recent rising edge.
  logic [W-1:0]     exp_q[$];
  bit               m_ah = 0, m_bh = 0, m_err = 0;
  logic [WIDTH-1:0] m_av = '0, m_bv = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  int               m_wait = 0;
  bit               acc_a, acc_b, was_single;

  always @(negedge clk) begin
    chk("a_ready",   {31'd0, bus.a_ready},   {31'd0, (!rst && !m_ah)});
    chk("b_ready",   {31'd0, bus.b_ready},   {31'd0, (!rst && !m_bh)});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (m_ah && m_bh)});
    chk("err",       {31'd0, bus.err},       {31'd0, m_err});
    chk("join_cnt",  32'(bus.join_cnt),      32'(m_cnt));
    chk("out1_hold", 32'(bus.out1),          32'(m_av));
    chk("out2_hold", 32'(bus.out2),          32'(m_bv));

    // Advance the model by the upcoming rising edge.
    if (rst) begin
      m_ah = 0; m_bh = 0; m_err = 0; m_av = '0; m_bv = '0; m_cnt = '0; m_wait = 0;
    end else begin
      m_err = 0;
      if (m_ah && m_bh) begin
        if (bus.out_ready) begin
          m_cnt = m_cnt + 1'b1;
          m_ah  = 0;
          m_bh  = 0;
        end
      end else begin
        was_single = m_ah ^ m_bh;
        acc_a = bus.a_valid && !m_ah;
        acc_b = bus.b_valid && !m_bh;
        if (acc_a) begin m_av = bus.a_data; m_ah = 1; end
        if (acc_b) begin m_bv = bus.b_data; m_bh = 1; end
        if (m_ah && m_bh) begin
          exp_q.push_back({m_av, m_bv});
        end else if (was_single) begin
          if (TIMEOUT != 0 && m_wait == TIMEOUT - 1) begin
            m_ah = 0; m_bh = 0; m_err = 1;
          end else begin
            m_wait++;
          end
        end else if (m_ah || m_bh) begin
          m_wait = 0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] exp_pair;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pair at %0t: got %0h expected no output", $time,
                 {bus.out1, bus.out2});
      end else begin
        exp_pair = exp_q.pop_front();
        chk("pair", 32'({bus.out1, bus.out2}), 32'(exp_pair));
        n_pops++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int pops_before;
  int density;

  initial begin
    bus.a_valid = 0; bus.a_data = '0; bus.b_valid = 0; bus.b_data = '0; bus.out_ready = 0;
    rst = 1;
    idle(3, 1'b0);
    rst = 0;

    // A first, B three cycles later, downstream ready.
    drive(1, 4'h1, 0, '0, 1);
    idle(2, 1'b1);
    drive(0, '0, 1, 4'h0, 1);
    idle(3, 1'b1);

    // Both in the same cycle, downstream stalls three cycles.
    drive(1, 4'h1, 1, 4'h1, 0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // B alone: timeout and err pulse.
    drive(0, '0, 1, 4'h5, 1);
    idle(TIMEOUT + 3, 1'b1);

    // B alone, A arrives exactly on the expiry cycle.
    drive(0, '0, 1, 4'h6, 1);
    idle(TIMEOUT - 1, 1'b1);
    drive(1, 4'h9, 0, '0, 1);
    idle(3, 1'b1);

    // Reset while A is held, then a fresh pair.
    drive(1, 4'h3, 0, '0, 1);
    idle(2, 1'b1);
    rst = 1;
    idle(1, 1'b1);
    rst = 0;
    idle(1, 1'b1);
    drive(1, 4'hA, 1, 4'hB, 1);
    idle(2, 1'b1);

    // 256 back-to-back joins: counter wraps, one pair every two cycles.
    pops_before = n_pops;
    for (int i = 0; i < 512; i++)
      drive(1, 4'($urandom), 1, 4'($urandom), 1);
    idle(2, 1'b1);
    chk("b2b_pairs", 32'(n_pops - pops_before), 32'd256);

    // Random traffic with varying density so both joins and timeouts occur.
    for (int seg = 0; seg < 20; seg++) begin
      density = $urandom_range(1, 40);
      for (int i = 0; i < 80; i++)
        drive($urandom_range(0, 99) < density, 4'($urandom),
              $urandom_range(0, 99) < density, 4'($urandom),
              $urandom_range(0, 3) != 0);
    end

    // Drain.
    idle(TIMEOUT + 4, 1'b1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
